ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction-fetch front end for the single-issue MIPS core.
- Holds the PC, requests 32-bit words from instruction memory over a req/ready handshake, and presents each instruction to the control decoder.
- The decoder receives the instruction's opcode[31:26] and funct[5:0] fields from this block.
- Takes the decoder's jump/branch results plus the ALU zero flag back, computes the next PC, and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/opcode/funct/pc_out are valid.
- instr_ready  in  1  downstream consumes the instruction this cycle.
- instr  out  32  registered instruction word.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- pc_out  out  32  address of the presented instruction.
- jump  in  1  decoder: the presented instruction is a J-type jump.
- branch  in  1  decoder: the presented instruction is a conditional branch.
- zero  in  1  ALU zero flag for the presented instruction.
- retired  out  32  count of consumed instructions.

Behaviour:
- States: S_START, S_FETCH, S_HOLD; state is registered.
- Reset, asynchronous, rst_n=0:
  - state=S_START, pc=RESET_PC, instr=0, retired=0.
  - imem_req=0, instr_valid=0. Both outputs drop immediately, mid-transfer included; an in-flight fetch is abandoned.
- S_START: next edge -> S_FETCH. Gives exactly one idle cycle after reset release.
- S_FETCH:
  - imem_req=1, imem_addr=pc held stable.
  - On an edge with imem_ready=1: instr<=imem_rdata, pc_out<=pc, go to S_HOLD.
  - Otherwise stay; wait is unbounded.
- S_HOLD:
  - instr_valid=1, imem_req=0. instr/opcode/funct/pc_out stay stable until accepted.
  - On an edge with instr_ready=1:
    - retired<=retired+1, wrapping 32'hFFFF_FFFF -> 0.
    - pc<=next_pc, go to S_FETCH.
- imem_req and instr_valid are decoded from the registered state; they are never both 1.
- next_pc, with p4 = pc_out+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0):
  - jump=1: {p4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - else branch=1 and zero=1: p4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), mod 2^32.
  - else: p4.
- jump/branch/zero are sampled only on the accepting edge; they are don't-care otherwise.
- Latency and throughput:
  - Memory ready in the same cycle as the request: instr_valid is asserted the next cycle.
  - instr_ready already high: the next imem_req is asserted the cycle after acceptance.
  - Best case is one instruction per 2 cycles.
- pc[1:0] is always 2'b00, since all targets are word-aligned by construction.

Test Plan:
- Reset release, imem_ready tied 1, instr_ready tied 1, nop stream -> imem_addr sequence 3000, 3004, 3008 on consecutive S_FETCH cycles; retired=3 after the third acceptance.
- Instr 32'h0800_0C10 (j) at 3000 with jump=1 -> next imem_addr=0000_3040; opcode=6'h02, funct=6'h10.
- beq at 3010, imm=16'hFFFF, branch=1, zero=1 -> next addr 3010. With zero=0 -> next addr 3014.
- imem_ready held 0 for 5 cycles -> imem_req stays 1 and imem_addr is unchanged. Then instr_ready held 0 for 4 cycles in S_HOLD -> instr and pc_out are unchanged and retired does not increment.
- pc forced to FFFF_FFFC by a jump chain, sequential instruction -> next addr 0000_0000.
- rst_n pulsed low while in S_FETCH with imem_req=1 -> imem_req=0 and instr_valid=0 immediately. After release: one idle cycle, then fetch from 3000 with retired=0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: holds the PC, fetches words over a req/ready
// handshake, presents them to the decoder and resolves the next PC on acceptance.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc_out,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {S_START, S_FETCH, S_HOLD} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pcOut_q;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic [31:0] pcPlus4;
  logic [31:0] jumpTarget;
  logic [31:0] branchTarget;
  logic [31:0] pc_d;

  // Next PC is resolved from the held instruction; jump outranks a taken branch.
  always_comb begin
    pcPlus4      = pcOut_q + 32'd4;
    jumpTarget   = {pcPlus4[31:28], instr_q[25:0], 2'b00};
    branchTarget = pcPlus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    pc_d         = pcPlus4;
    if (jump) begin
      pc_d = jumpTarget;
    end else if (branch && zero) begin
      pc_d = branchTarget;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_START;
      pc_q      <= {RESET_PC[31:2], 2'b00};
      pcOut_q   <= {RESET_PC[31:2], 2'b00};
      instr_q   <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      case (state_q)
        S_START: state_q <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            pcOut_q <= pc_q;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            retired_q <= retired_q + 32'd1;
            pc_q      <= pc_d;
            state_q   <= S_FETCH;
          end
        end
        default: state_q <= S_START;
      endcase
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_HOLD);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc_out      = pcOut_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: stimulus pushes expected fetch addresses and
// presented instructions into queues, a negedge monitor pops and compares them.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_out;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] retired;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } instrExp_t;

  logic [31:0] addrQ[$];
  instrExp_t   instrQ[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] expRetired = 32'd0;

  ifetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .funct(funct), .pc_out(pc_out),
    .jump(jump), .branch(branch), .zero(zero), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // One full transaction: fetch expAddr (optionally stalled), then hold the
  // instruction (optionally stalled) and accept it with the given decoder inputs.
  task automatic applyStimulus(input logic [31:0] expAddr, input logic [31:0] word,
                               input logic j, input logic b, input logic z,
                               input int fetchStall, input int holdStall);
    int waitCycles = 0;
    while (!imem_req && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!imem_req) begin
      checkOutput("fetchTimeout", {31'd0, imem_req}, 32'd1);
      return;
    end
    addrQ.push_back(expAddr);
    repeat (fetchStall) begin
      imem_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput("stallReq", {31'd0, imem_req}, 32'd1);
      checkOutput("stallAddr", imem_addr, expAddr);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    instrQ.push_back('{pc: expAddr, word: word});
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    checkOutput("validLatency", {31'd0, instr_valid}, 32'd1);
    checkOutput("reqInHold", {31'd0, imem_req}, 32'd0);
    repeat (holdStall) begin
      instr_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput("holdInstr", instr, word);
      checkOutput("holdPc", pc_out, expAddr);
      checkOutput("holdRetired", retired, expRetired);
      checkOutput("holdValid", {31'd0, instr_valid}, 32'd1);
    end
    instr_ready = 1'b1;
    jump = j;
    branch = b;
    zero = z;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    jump = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
    expRetired = expRetired + 32'd1;
    checkOutput("retired", retired, expRetired);
    checkOutput("reqAfterAccept", {31'd0, imem_req}, 32'd1);
  endtask

  // Monitor: compare every completed fetch and every accepted instruction.
  always @(negedge clk) begin
    if (rst_n && imem_req && imem_ready) begin
      if (addrQ.size() == 0) begin
        checkOutput("unexpectedFetch", imem_addr, 32'hFFFF_FFFF);
      end else begin
        checkOutput("fetchAddr", imem_addr, addrQ.pop_front());
      end
    end
    if (rst_n && instr_valid && instr_ready) begin
      if (instrQ.size() == 0) begin
        checkOutput("unexpectedInstr", instr, 32'hFFFF_FFFF);
      end else begin
        instrExp_t e;
        e = instrQ.pop_front();
        checkOutput("instr", instr, e.word);
        checkOutput("pcOut", pc_out, e.pc);
        checkOutput("opcode", {26'd0, opcode}, {26'd0, e.word[31:26]});
        checkOutput("funct", {26'd0, funct}, {26'd0, e.word[5:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReq", {31'd0, imem_req}, 32'd0);
    checkOutput("rstValid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rstAddr", imem_addr, 32'h0000_3000);
    checkOutput("rstInstr", instr, 32'd0);
    checkOutput("rstRetired", retired, 32'd0);
    rst_n = 1'b1;
    checkOutput("idleReq", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    checkOutput("firstReq", {31'd0, imem_req}, 32'd1);

    // Sequential nop stream, memory and decoder always ready
    applyStimulus(32'h0000_3000, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(32'h0000_3004, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    applyStimulus(32'h0000_3008, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("retiredThree", retired, 32'd3);

    // Memory stall 5 cycles, consumer stall 4 cycles
    applyStimulus(32'h0000_300C, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 5, 4);

    // beq imm=-1: taken loops to itself, not-taken falls through
    applyStimulus(32'h0000_3010, 32'h1000_FFFF, 1'b0, 1'b1, 1'b1, 0, 0);
    applyStimulus(32'h0000_3010, 32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 0, 0);

    // j 0x0C10 with branch also asserted: jump wins, target 0x3040
    applyStimulus(32'h0000_3014, 32'h0800_0C10, 1'b1, 1'b1, 1'b1, 0, 1);
    checkOutput("jOpcode", {26'd0, opcode}, 32'h0000_0002);
    checkOutput("jFunct", {26'd0, funct}, 32'h0000_0010);

    // Jump chain climbing one region per jump to FFFF_FFFC
    applyStimulus(32'h0000_3040, 32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      n = i;
      a = {n[3:0], 28'hFFF_FFFC};
      applyStimulus(a, 32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 0, 0);
    end
    applyStimulus(32'hFFFF_FFFC, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("wrapAddr", imem_addr, 32'h0000_0000);
    checkOutput("wrapReq", {31'd0, imem_req}, 32'd1);

    // Asynchronous reset in the middle of a fetch
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReq", {31'd0, imem_req}, 32'd0);
    checkOutput("asyncValid", {31'd0, instr_valid}, 32'd0);
    checkOutput("asyncRetired", retired, 32'd0);
    checkOutput("asyncAddr", imem_addr, 32'h0000_3000);
    expRetired = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("reIdleReq", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    checkOutput("reReq", {31'd0, imem_req}, 32'd1);
    checkOutput("reAddr", imem_addr, 32'h0000_3000);
    applyStimulus(32'h0000_3000, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("reRetired", retired, 32'd1);

    @(posedge clk); #1;
    checkOutput("addrQEmpty", addrQ.size(), 32'd0);
    checkOutput("instrQEmpty", instrQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
